// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the FSM state encoding and the bit-counter width helper.
// No logic of its own; imported by the multiplier top.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_array_multiplier.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement per operation.
// Latency: out_valid rises WIDTH cycles after the accepting edge; one product per WIDTH+2 cycles.
// Backpressure: holds p and out_valid in DONE until out_ready; in_ready low outside IDLE.
module seq_array_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             neg;
  logic [PW-1:0]    acc;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    prod;

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (count == CW'(WIDTH - 1));

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (is_signed && a[WIDTH-1]) a_mag = ~a + WIDTH'(1);
    if (is_signed && b[WIDTH-1]) b_mag = ~b + WIDTH'(1);
  end

  // Partial product for this multiplier bit, running sum and sign-corrected final result.
  always_comb begin
    addend  = '0;
    if (mplier[0]) addend = {{WIDTH{1'b0}}, mcand} << count;
    acc_sum = acc + addend;
    prod    = neg ? (~acc_sum + PW'(1)) : acc_sum;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, WIDTH cycles of CALC, wait for consumer in DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, one shift-add per CALC cycle, load p on the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      p      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last) p <= prod;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Self-checking bench for seq_array_multiplier at WIDTH=4 and WIDTH=16.
// Reference products come from plain signed/unsigned integer multiplication.
// Scenarios run in sequence from one initial block and end with a summary line.
module tb_seq_array_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        iv4, ir4, ov4, or4, s4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  logic        iv16, ir16, ov16, or16, s16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_array_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .p(p4)
  );

  seq_array_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .p(p16)
  );

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 8'(x * y);
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  // One operation on the 4-bit instance; lat counts edges from acceptance to out_valid.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s, input int hold,
                      output logic [7:0] res, output int lat);
    int w;
    w = 0;
    while (!ir4 && w < 100) begin @(posedge clk); #1; w++; end
    a4 = a; b4 = b; s4 = s; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
    lat = 0;
    while (!ov4 && lat < 100) begin @(posedge clk); #1; lat++; end
    repeat (hold) begin @(posedge clk); #1; end
    res = p4;
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [31:0] res, output int lat);
    int w;
    w = 0;
    while (!ir16 && w < 100) begin @(posedge clk); #1; w++; end
    a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 100) begin @(posedge clk); #1; lat++; end
    res = p16;
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv4 = 0; or4 = 0; s4 = 0; a4 = 0; b4 = 0;
    iv16 = 0; or16 = 0; s16 = 0; a16 = 0; b16 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", ir4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov4); end
    checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL reset_p4: got %h expected 00", p4); end
    checks++; if (p16 !== 32'h0) begin errors++; $display("FAIL reset_p16: got %h expected 0", p16); end
    rst_n = 1'b1;
    #1;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", ir4); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed4();
    logic [3:0] ta [6] = '{4'd3, 4'd10, 4'd15, 4'hD, 4'h8, 4'h8};
    logic [3:0] tb [6] = '{4'd2, 4'd10, 4'd15, 4'h5, 4'h8, 4'h7};
    logic       ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] te [6] = '{8'h06, 8'h64, 8'hE1, 8'hF1, 8'h40, 8'hC8};
    logic [7:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run4(ta[i], tb[i], ts[i], 0, res, lat);
      checks++;
      if (res !== te[i]) begin
        errors++; $display("FAIL directed4[%0d] p: got %h expected %h", i, res, te[i]);
      end
      checks++;
      if (lat != 4) begin
        errors++; $display("FAIL directed4[%0d] latency: got %0d expected 4", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    a4 = 4'd6; b4 = 4'd7; s4 = 1'b0; iv4 = 1'b1;
    @(posedge clk); #1;
    w = 0;
    // Keep offering different operands while busy; none may be taken.
    while (!ov4 && w < 100) begin
      a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom); iv4 = ~iv4;
      checks++;
      if (ir4 !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %b expected 0", ir4); end
      @(posedge clk); #1; w++;
    end
    for (int i = 0; i < 3; i++) begin
      iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
      checks++;
      if (p4 !== 8'd42 || ov4 !== 1'b1 || ir4 !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got p=%h ov=%b ir=%b expected p=2a ov=1 ir=0", i, p4, ov4, ir4);
      end
      @(posedge clk); #1;
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0; iv4 = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1 || p4 !== 8'd42) begin
      errors++;
      $display("FAIL consume: got p=%h ov=%b ir=%b expected p=2a ov=0 ir=1", p4, ov4, ir4);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    int lat;
    int seen;
    a4 = 4'd9; b4 = 4'd9; s4 = 1'b0; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b0 || p4 !== 8'h00 || ir4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got p=%h ov=%b ir=%b expected p=00 ov=0 ir=0", p4, ov4, ir4);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ir4 !== 1'b1) begin errors++; $display("FAIL mid_reset_idle: got in_ready=%b expected 1", ir4); end
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (ov4) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL stale_out_valid: got %0d pulses expected 0", seen); end
    run4(4'd5, 4'd3, 1'b0, 0, res, lat);
    checks++;
    if (res !== 8'h0F || lat != 4) begin
      errors++; $display("FAIL after_reset: got p=%h lat=%0d expected p=0f lat=4", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ra, rb;
    logic       rs;
    logic [7:0] res, expv;
    int lat;
    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
      expv = ref4(ra, rb, rs);
      run4(ra, rb, rs, int'($urandom_range(0, 3)), res, lat);
      checks++;
      if (res !== expv || lat != 4) begin
        errors++;
        $display("FAIL b2b[%0d] %h*%h s=%b: got p=%h lat=%0d expected p=%h lat=4", i, ra, rb, rs, res, lat, expv);
      end
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_wide();
    logic [15:0] ra, rb;
    logic        rs;
    logic [31:0] res, expv;
    int lat;
    run16(16'hFFFF, 16'hFFFF, 1'b0, res, lat);
    checks++;
    if (res !== 32'hFFFE0001 || lat != 16) begin
      errors++; $display("FAIL wide_unsigned: got p=%h lat=%0d expected p=fffe0001 lat=16", res, lat);
    end
    run16(16'h8000, 16'h8000, 1'b1, res, lat);
    checks++;
    if (res !== 32'h40000000 || lat != 16) begin
      errors++; $display("FAIL wide_signed: got p=%h lat=%0d expected p=40000000 lat=16", res, lat);
    end
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      expv = ref16(ra, rb, rs);
      run16(ra, rb, rs, res, lat);
      checks++;
      if (res !== expv) begin
        errors++; $display("FAIL wide_rand[%0d] %h*%h s=%b: got %h expected %h", i, ra, rb, rs, res, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed4();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
